// File: rtl/tm_pkg.sv
// Shared definitions for the TM ALU family.
// FSM encoding and width helpers.
package tm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DIV,
        WB
    } tmState_t;

    function automatic int sumWidth(input int w, input int c);
        return w + c + 1;
    endfunction

    function automatic int chWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tm_seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle.
// done is high during the cycle whose closing edge writes the last bit.
module tm_seq_divider #(
    parameter int DIVIDEND_W = 17,
    parameter int DIVISOR_W  = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient
);

    localparam int IT_W = $clog2(DIVIDEND_W + 1);

    logic [DIVISOR_W-1:0]  rem;
    logic [DIVISOR_W-1:0]  dvsr;
    logic [DIVIDEND_W-1:0] quo;
    logic [IT_W-1:0]       iter;
    logic [DIVISOR_W:0]    trial;
    logic [DIVISOR_W:0]    diff;
    logic                  fits;

    always_comb begin
        trial = {rem, quo[DIVIDEND_W-1]};
        diff  = trial - {1'b0, dvsr};
        fits  = (trial >= {1'b0, dvsr});
    end

    assign done     = busy && (iter == IT_W'(1));
    assign quotient = quo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem  <= '0;
            dvsr <= '0;
            quo  <= '0;
            iter <= '0;
            busy <= 1'b0;
        end else if (start) begin
            rem  <= '0;
            dvsr <= divisor;
            quo  <= dividend;
            iter <= IT_W'(DIVIDEND_W);
            busy <= 1'b1;
        end else if (busy) begin
            // remainder stays below the divisor, so it fits DIVISOR_W bits
            rem  <= fits ? diff[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
            quo  <= {quo[DIVIDEND_W-2:0], fits};
            iter <= iter - IT_W'(1);
            if (iter == IT_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tm_avg_tracker.sv
// Per-channel running average (exact or EMA) of TM transaction length.
// One request in flight; result and channel state written in WB.
module tm_avg_tracker
    import tm_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_W     = 8,
    parameter int NCH       = 4,
    parameter int EMA_SHIFT = 3,
    localparam int CH_W     = chWidth(NCH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH_W-1:0]  in_ch,
    input  logic [WIDTH-1:0] in_len,
    input  logic             in_clr,
    input  logic             ema_mode,
    output logic             out_valid,
    output logic [CH_W-1:0]  out_ch,
    output logic [WIDTH-1:0] out_avg,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_sat
);

    localparam int SUM_W = sumWidth(WIDTH, CNT_W);
    localparam int DIV_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    tmState_t state;
    tmState_t nextState;

    logic [WIDTH-1:0] avgMem [NCH];
    logic [CNT_W-1:0] cntMem [NCH];

    logic [CH_W-1:0]  reqCh;
    logic [WIDTH-1:0] reqLen;
    logic             reqClr;
    logic             reqEma;

    logic [WIDTH-1:0] curAvg;
    logic [CNT_W-1:0] curCnt;
    logic [SUM_W-1:0] macSum;
    logic [DIV_W-1:0] divisor;
    logic [SUM_W-1:0] quotient;
    logic             divBusy;
    logic             divDone;
    logic             transfer;

    logic signed [WIDTH:0] emaDiff;
    logic signed [WIDTH:0] emaStep;
    logic signed [WIDTH:0] emaSum;
    logic [WIDTH-1:0]      emaAvg;
    logic [WIDTH-1:0]      divAvg;
    logic [WIDTH-1:0]      avgNew;
    logic [CNT_W-1:0]      cntNew;
    logic                  satNew;

    assign curAvg   = avgMem[reqCh];
    assign curCnt   = cntMem[reqCh];
    assign in_ready = (state == IDLE) && !divBusy;
    assign transfer = in_valid && in_ready;

    always_comb begin
        macSum  = SUM_W'(curAvg) * SUM_W'(curCnt) + SUM_W'(reqLen);
        divisor = DIV_W'(curCnt) + DIV_W'(1);
    end

    tm_seq_divider #(
        .DIVIDEND_W(SUM_W),
        .DIVISOR_W (DIV_W)
    ) uDiv (
        .clk     (clk),
        .reset   (reset),
        .start   (state == MAC),
        .dividend(macSum),
        .divisor (divisor),
        .busy    (divBusy),
        .done    (divDone),
        .quotient(quotient)
    );

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (transfer) begin
                    nextState = (in_clr || ema_mode) ? WB : MAC;
                end
            end
            MAC: nextState = DIV;
            DIV: begin
                if (divDone) begin
                    nextState = WB;
                end
            end
            WB: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // quotient and EMA are bounded by the inputs; the clamps never fire
    always_comb begin
        emaDiff = $signed({1'b0, reqLen}) - $signed({1'b0, curAvg});
        emaStep = emaDiff >>> EMA_SHIFT;
        emaSum  = $signed({1'b0, curAvg}) + emaStep;
        emaAvg  = emaSum[WIDTH] ? '0 : emaSum[WIDTH-1:0];
        divAvg  = (|quotient[SUM_W-1:WIDTH]) ? '1 : quotient[WIDTH-1:0];
    end

    always_comb begin
        avgNew = '0;
        cntNew = '0;
        satNew = 1'b0;
        if (!reqClr) begin
            cntNew = (curCnt == CNT_MAX) ? CNT_MAX : curCnt + 1'b1;
            satNew = (cntNew == CNT_MAX);
            if (!reqEma) begin
                avgNew = divAvg;
            end else if (curCnt == '0) begin
                avgNew = reqLen;
            end else begin
                avgNew = emaAvg;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                avgMem[i] <= '0;
                cntMem[i] <= '0;
            end
            reqCh     <= '0;
            reqLen    <= '0;
            reqClr    <= 1'b0;
            reqEma    <= 1'b0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_avg   <= '0;
            out_cnt   <= '0;
            out_sat   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (transfer) begin
                reqCh  <= in_ch;
                reqLen <= in_len;
                reqClr <= in_clr;
                reqEma <= ema_mode;
            end
            if (state == WB) begin
                avgMem[reqCh] <= avgNew;
                cntMem[reqCh] <= cntNew;
                out_valid     <= 1'b1;
                out_ch        <= reqCh;
                out_avg       <= avgNew;
                out_cnt       <= cntNew;
                out_sat       <= satNew;
            end
        end
    end

endmodule
